// File: rtl/pipelined_prefix_adder_if.sv
// Operand/result streaming bundle for pipelined_prefix_adder.
// out_ovf exists only when PREFIX_ADDER_OVERFLOW_EN is defined.
interface pipelined_prefix_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
`ifdef PREFIX_ADDER_OVERFLOW_EN
   logic             out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );
`else
   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout
   );
`endif
endinterface

// File: rtl/pipelined_prefix_adder.sv
// Fully pipelined Kogge-Stone adder with valid/ready and bubble collapsing.
// Define PREFIX_ADDER_OVERFLOW_EN to add the signed-overflow output.
module pipelined_prefix_adder #(
   parameter int WIDTH = 16
) (
   input logic                     clk,
   input logic                     rst_n,
   pipelined_prefix_adder_if.slave bus
);
   localparam int LEVELS = $clog2(WIDTH);
   localparam int LAST   = LEVELS + 1;

   typedef logic [WIDTH-1:0] word_t;

   localparam word_t         ONES  = '1;
   localparam logic [LAST:0] VONES = '1;

   if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
      $error("pipelined_prefix_adder: WIDTH must be a power of two >= 2");
   end

   logic [LAST:0]   v_q;
   logic [LAST:0]   ld;
   word_t           gen_q  [0:LEVELS];
   word_t           gen_d  [0:LEVELS];
   word_t           prop_q [0:LEVELS-1];
   word_t           prop_d [0:LEVELS-1];
   word_t           rp_q   [0:LEVELS];
   logic [LEVELS:0] cin_q;
   word_t           carry;
   word_t           sum_q, sum_d;
   logic            cout_q, cout_d;
`ifdef PREFIX_ADDER_OVERFLOW_EN
   logic            ovf_q, ovf_d;
`endif

   // A stage may load when it, or any stage below it, is empty.
   always_comb begin
      ld = '0;
      for (int n = 0; n <= LAST; n++) begin
         ld[n] = bus.out_ready | ~(&(v_q | ~(VONES << n)));
      end
   end

   // Carry-in enters as bit -1 (prop 0), merged into bit 0 up front.
   always_comb begin
      gen_d[0]     = bus.in_a & bus.in_b;
      prop_d[0]    = bus.in_a ^ bus.in_b;
      gen_d[0][0]  = gen_d[0][0] | (prop_d[0][0] & bus.in_cin);
      prop_d[0][0] = 1'b0;
      for (int k = 1; k <= LEVELS; k++) begin
         gen_d[k] = gen_q[k-1] |
                    (prop_q[k-1] & (gen_q[k-1] << (1 << (k - 1))));
      end
      for (int k = 1; k < LEVELS; k++) begin
         prop_d[k] = prop_q[k-1] &
                     ((prop_q[k-1] << (1 << (k - 1))) |
                      ~(ONES << (1 << (k - 1))));
      end
   end

   always_comb begin
      carry  = {gen_q[LEVELS][WIDTH-2:0], cin_q[LEVELS]};
      sum_d  = rp_q[LEVELS] ^ carry;
      cout_d = gen_q[LEVELS][WIDTH-1];
`ifdef PREFIX_ADDER_OVERFLOW_EN
      ovf_d  = gen_q[LEVELS][WIDTH-1] ^ gen_q[LEVELS][WIDTH-2];
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q    <= '0;
         cin_q  <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
`ifdef PREFIX_ADDER_OVERFLOW_EN
         ovf_q  <= 1'b0;
`endif
         for (int k = 0; k <= LEVELS; k++) begin
            gen_q[k] <= '0;
            rp_q[k]  <= '0;
         end
         for (int k = 0; k < LEVELS; k++) begin
            prop_q[k] <= '0;
         end
      end else begin
         if (ld[0]) begin
            v_q[0] <= bus.in_valid;
            if (bus.in_valid) begin
               gen_q[0]  <= gen_d[0];
               prop_q[0] <= prop_d[0];
               rp_q[0]   <= bus.in_a ^ bus.in_b;
               cin_q[0]  <= bus.in_cin;
            end
         end
         for (int k = 1; k <= LEVELS; k++) begin
            if (ld[k]) begin
               v_q[k] <= v_q[k-1];
               if (v_q[k-1]) begin
                  gen_q[k] <= gen_d[k];
                  rp_q[k]  <= rp_q[k-1];
                  cin_q[k] <= cin_q[k-1];
               end
            end
         end
         for (int k = 1; k < LEVELS; k++) begin
            if (ld[k] && v_q[k-1]) begin
               prop_q[k] <= prop_d[k];
            end
         end
         if (ld[LAST]) begin
            v_q[LAST] <= v_q[LEVELS];
            if (v_q[LEVELS]) begin
               sum_q  <= sum_d;
               cout_q <= cout_d;
`ifdef PREFIX_ADDER_OVERFLOW_EN
               ovf_q  <= ovf_d;
`endif
            end
         end
      end
   end

   assign bus.in_ready  = ld[0];
   assign bus.out_valid = v_q[LAST];
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;
`ifdef PREFIX_ADDER_OVERFLOW_EN
   assign bus.out_ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed bench for pipelined_prefix_adder at WIDTH=16.
// Covers latency, wrap, streaming, backpressure, sparse traffic, reset.
module tb_pipelined_prefix_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   pipelined_prefix_adder_if #(.WIDTH(16)) bus ();

   pipelined_prefix_adder #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.in_cin = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b want 0", bus.out_valid);
      end
      n_chk++;
      if (bus.out_sum !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_sum: got %h want 0000", bus.out_sum);
      end
      n_chk++;
      if (bus.out_cout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cout: got %b want 0", bus.out_cout);
      end
      n_chk++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      bus.in_a = 16'h1234;
      bus.in_b = 16'h4321;
      bus.in_cin = 1'b0;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      n_chk++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_in_ready: got %b want 1", bus.in_ready);
      end
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         #1;
         n_chk++;
         if (bus.out_valid !== (n == 6)) begin
            n_fail++;
            $display("FAIL single_latency: cyc %0d got %b want %b",
                     n, bus.out_valid, (n == 6));
         end
      end
      n_chk++;
      if ({bus.out_cout, bus.out_sum} !== 17'h05555) begin
         n_fail++;
         $display("FAIL single_sum: got %b/%h want 0/5555",
                  bus.out_cout, bus.out_sum);
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      bus.in_a = 16'hFFFF;
      bus.in_b = 16'h0000;
      bus.in_cin = 1'b1;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         #1;
         n_chk++;
         if (bus.out_valid !== (n == 6)) begin
            n_fail++;
            $display("FAIL wrap_latency: cyc %0d got %b", n, bus.out_valid);
         end
      end
      n_chk++;
      if ({bus.out_cout, bus.out_sum} !== 17'h10000) begin
         n_fail++;
         $display("FAIL wrap_sum: got %b/%h want 1/0000",
                  bus.out_cout, bus.out_sum);
      end
   endtask

`ifdef PREFIX_ADDER_OVERFLOW_EN
   task automatic test_ovf();
      @(negedge clk);
      bus.in_a = 16'h7FFF;
      bus.in_b = 16'h0001;
      bus.in_cin = 1'b0;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         #1;
      end
      n_chk++;
      if ({bus.out_ovf, bus.out_cout, bus.out_sum} !== 18'h28000) begin
         n_fail++;
         $display("FAIL ovf: got ovf %b cout %b sum %h want 1/0/8000",
                  bus.out_ovf, bus.out_cout, bus.out_sum);
      end
   endtask
`endif

   task automatic test_back_to_back();
      logic [15:0] va [100];
      logic [15:0] vb [100];
      logic        vc [100];
      logic [16:0] exp_v;
      int          j;
      for (int i = 0; i < 100; i++) begin
         va[i] = 16'($urandom);
         vb[i] = 16'($urandom);
         vc[i] = 1'($urandom);
      end
      for (int c = 0; c < 106; c++) begin
         @(negedge clk);
         bus.out_ready = 1'b1;
         if (c < 100) begin
            bus.in_valid = 1'b1;
            bus.in_a = va[c];
            bus.in_b = vb[c];
            bus.in_cin = vc[c];
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (c < 100) begin
            n_chk++;
            if (bus.in_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_in_ready: cyc %0d got 0 want 1", c);
            end
         end
         n_chk++;
         if (bus.out_valid !== (c >= 6)) begin
            n_fail++;
            $display("FAIL b2b_valid: cyc %0d got %b", c, bus.out_valid);
         end
         if (c >= 6) begin
            j = c - 6;
            exp_v = 17'(va[j]) + 17'(vb[j]) + 17'(vc[j]);
            n_chk++;
            if ({bus.out_cout, bus.out_sum} !== exp_v) begin
               n_fail++;
               $display("FAIL b2b_sum[%0d]: got %h want %h",
                        j, {bus.out_cout, bus.out_sum}, exp_v);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] ba [8];
      logic [15:0] bb [8];
      logic        bc [8];
      logic [16:0] exp_v;
      int          acc;
      for (int i = 0; i < 8; i++) begin
         ba[i] = 16'(16'h0101 * (i + 1));
         bb[i] = 16'hF111;
         bc[i] = 1'(i);
      end
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus.out_ready = 1'b0;
         bus.in_valid = 1'b1;
         bus.in_a = ba[acc];
         bus.in_b = bb[acc];
         bus.in_cin = bc[acc];
         #1;
         n_chk++;
         if (bus.in_ready !== (c < 6)) begin
            n_fail++;
            $display("FAIL bp_in_ready: cyc %0d got %b", c, bus.in_ready);
         end
         if (bus.in_ready === 1'b1) acc++;
         n_chk++;
         if (bus.out_valid !== (c >= 6)) begin
            n_fail++;
            $display("FAIL bp_valid: cyc %0d got %b", c, bus.out_valid);
         end
         if (c >= 6) begin
            exp_v = 17'(ba[0]) + 17'(bb[0]) + 17'(bc[0]);
            n_chk++;
            if ({bus.out_cout, bus.out_sum} !== exp_v) begin
               n_fail++;
               $display("FAIL bp_hold: cyc %0d got %h want %h",
                        c, {bus.out_cout, bus.out_sum}, exp_v);
            end
         end
      end
      n_chk++;
      if (acc !== 6) begin
         n_fail++;
         $display("FAIL bp_accepted: got %0d want 6", acc);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      n_chk++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
      end
      for (int d = 0; d < 6; d++) begin
         if (d > 0) begin
            @(negedge clk);
            #1;
         end
         exp_v = 17'(ba[d]) + 17'(bb[d]) + 17'(bc[d]);
         n_chk++;
         if (bus.out_valid !== 1'b1 ||
             {bus.out_cout, bus.out_sum} !== exp_v) begin
            n_fail++;
            $display("FAIL bp_drain[%0d]: got v%b %h want v1 %h",
                     d, bus.out_valid, {bus.out_cout, bus.out_sum}, exp_v);
         end
      end
      @(negedge clk);
      #1;
      n_chk++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_empty: got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_sparse();
      logic [16:0] q[$];
      logic [16:0] held;
      logic [16:0] exp_v;
      logic [15:0] sa, sb;
      logic        sc;
      logic        pend, stall;
      int          sent, got;
      pend = 1'b0;
      stall = 1'b0;
      sent = 0;
      got = 0;
      held = '0;
      sa = '0;
      sb = '0;
      sc = 1'b0;
      for (int c = 0; c < 400 && got < 20; c++) begin
         @(negedge clk);
         if (!pend && sent < 20 && (c % 3) == 0) begin
            pend = 1'b1;
            sa = 16'($urandom);
            sb = 16'($urandom);
            sc = 1'($urandom);
         end
         bus.in_valid = pend;
         bus.in_a = sa;
         bus.in_b = sb;
         bus.in_cin = sc;
         bus.out_ready = 1'($urandom);
         #1;
         if (stall) begin
            n_chk++;
            if (bus.out_valid !== 1'b1 ||
                {bus.out_cout, bus.out_sum} !== held) begin
               n_fail++;
               $display("FAIL sparse_stable: cyc %0d got v%b %h want v1 %h",
                        c, bus.out_valid, {bus.out_cout, bus.out_sum}, held);
            end
         end
         stall = 1'b0;
         if (bus.out_valid === 1'b1) begin
            if (bus.out_ready) begin
               n_chk++;
               if (q.size() == 0) begin
                  n_fail++;
                  $display("FAIL sparse_dup: got %h want none",
                           {bus.out_cout, bus.out_sum});
               end else begin
                  exp_v = q.pop_front();
                  if ({bus.out_cout, bus.out_sum} !== exp_v) begin
                     n_fail++;
                     $display("FAIL sparse_sum: got %h want %h",
                              {bus.out_cout, bus.out_sum}, exp_v);
                  end
               end
               got++;
            end else begin
               held = {bus.out_cout, bus.out_sum};
               stall = 1'b1;
            end
         end
         if (bus.in_valid && bus.in_ready === 1'b1) begin
            q.push_back(17'(sa) + 17'(sb) + 17'(sc));
            sent++;
            pend = 1'b0;
         end
      end
      n_chk++;
      if (got !== 20 || q.size() != 0) begin
         n_fail++;
         $display("FAIL sparse_count: got %0d left %0d want 20/0",
                  got, q.size());
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         n_chk++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sparse_extra: got %h want none",
                     {bus.out_cout, bus.out_sum});
         end
      end
   endtask

   task automatic test_reset_midstream();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_a = 16'(16'h1111 * (i + 1));
         bus.in_b = 16'h0F0F;
         bus.in_cin = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk++;
      if ({bus.out_valid, bus.out_cout, bus.out_sum} !== 18'h0) begin
         n_fail++;
         $display("FAIL midrst_clear: got v%b c%b %h want 0/0/0000",
                  bus.out_valid, bus.out_cout, bus.out_sum);
      end
      n_chk++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_ready: got %b want 1", bus.in_ready);
      end
      @(negedge clk);
      bus.in_a = 16'h0001;
      bus.in_b = 16'h0001;
      bus.in_cin = 1'b0;
      bus.in_valid = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         #1;
         n_chk++;
         if (bus.out_valid !== (n == 6)) begin
            n_fail++;
            $display("FAIL midrst_stale: cyc %0d got %b", n, bus.out_valid);
         end
         if (n == 6) begin
            n_chk++;
            if ({bus.out_cout, bus.out_sum} !== 17'h00002) begin
               n_fail++;
               $display("FAIL midrst_sum: got %h want 00002",
                        {bus.out_cout, bus.out_sum});
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_wrap();
`ifdef PREFIX_ADDER_OVERFLOW_EN
      test_ovf();
`endif
      test_back_to_back();
      test_backpressure();
      test_sparse();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
